// File: rtl/mul_share_arbiter_pkg.sv
// mul_share_pkg: state encoding and width helpers for the shared-multiplier arbiter
package mul_share_pkg;
   typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, WAIT, DRAIN, RESP} state_e;
   function automatic int out_width(input int w);
      return 2 * w;
   endfunction
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if: requester, response and multiplier signals of the arbiter
interface mul_share_arbiter_if #(parameter int N_REQ = 3, parameter int WIDTH = 4);
   localparam int ID_W = mul_share_pkg::id_width(N_REQ);
   localparam int OW = mul_share_pkg::out_width(WIDTH);
   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic resp_valid;
   logic resp_ready;
   logic [ID_W-1:0] resp_id;
   logic [OW-1:0] resp_o;
   logic mul_in_valid;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [OW-1:0] mul_o;
   logic mul_out_valid;
   logic busy;
   modport master (
      input req_valid, req_a, req_b, resp_ready, mul_o, mul_out_valid,
      output req_ready, resp_valid, resp_id, resp_o, mul_in_valid, mul_a, mul_b, busy
   );
   modport slave (
      output req_valid, req_a, req_b, resp_ready, mul_o, mul_out_valid,
      input req_ready, resp_valid, resp_id, resp_o, mul_in_valid, mul_a, mul_b, busy
   );
endinterface

// File: rtl/mul_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr (wrapping)
module rr_pick #(
   parameter int N_REQ = 3,
   parameter int ID_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  grant,
   output logic             any
);
   logic [ID_W-1:0] idx;
   // Scan from the farthest offset back so the nearest valid index wins last
   always_comb begin
      grant = '0;
      idx = '0;
      any = |req;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = ID_W'((int'(ptr) + i) % N_REQ);
         if (req[idx]) grant = idx;
      end
   end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one external sequential multiplier among N_REQ clients
// Optional MUL_SHARE_ZERO_BYPASS_EN answers zero-operand requests without using the multiplier.
module mul_share_arbiter
   import mul_share_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int WIDTH = 4,
   parameter int FLUSH_CYC = 2 * WIDTH + 4
) (
   input logic clk,
   input logic rst,
   mul_share_arbiter_if.master bus
);
   localparam int ID_W = id_width(N_REQ);
   localparam int OW = out_width(WIDTH);
   localparam int CW = $clog2(FLUSH_CYC + 1);
   localparam logic [2:0] S_FLUSH = 3'(FLUSH);
   localparam logic [2:0] S_IDLE = 3'(IDLE);
   localparam logic [2:0] S_ISSUE = 3'(ISSUE);
   localparam logic [2:0] S_WAIT = 3'(WAIT);
   localparam logic [2:0] S_DRAIN = 3'(DRAIN);
   localparam logic [2:0] S_RESP = 3'(RESP);
   logic [2:0] state;
   logic [CW-1:0] cnt;
   logic [ID_W-1:0] ptr, g, pick;
   logic [WIDTH-1:0] a_q, b_q, a_in, b_in;
   logic [WIDTH-1:0] a_arr [N_REQ];
   logic [WIDTH-1:0] b_arr [N_REQ];
   logic [OW-1:0] o_q;
   logic any, accept, zero, op;
   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
      assign b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
   end
   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req(bus.req_valid),
      .ptr(ptr),
      .grant(pick),
      .any(any)
   );
   assign a_in = a_arr[pick];
   assign b_in = b_arr[pick];
   assign accept = (state == S_IDLE) && any;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
   assign zero = (a_in == '0) || (b_in == '0);
`else
   assign zero = 1'b0;
`endif
   assign op = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DRAIN);
   assign bus.req_ready = accept ? (N_REQ'(1) << pick) : '0;
   assign bus.mul_in_valid = state == S_ISSUE;
   assign bus.mul_a = op ? a_q : '0;
   assign bus.mul_b = op ? b_q : '0;
   assign bus.resp_valid = state == S_RESP;
   assign bus.resp_id = g;
   assign bus.resp_o = o_q;
   assign bus.busy = state != S_IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FLUSH;
         cnt <= '0;
         ptr <= '0;
         g <= '0;
         a_q <= '0;
         b_q <= '0;
         o_q <= '0;
      end else begin
         case (state)
            S_FLUSH: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(FLUSH_CYC - 1)) state <= S_IDLE;
            end
            S_IDLE: if (any) begin
               g <= pick;
               a_q <= a_in;
               b_q <= b_in;
               if (zero) o_q <= '0;
               state <= zero ? S_RESP : S_ISSUE;
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: if (bus.mul_out_valid) begin
               o_q <= bus.mul_o;
               state <= S_DRAIN;
            end
            // Hold off until done drops so a lingering done cannot complete the next op
            S_DRAIN: if (!bus.mul_out_valid) state <= S_RESP;
            S_RESP: if (bus.resp_ready) begin
               ptr <= (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_FLUSH;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench with a behavioural multiplier and round-robin reference model
module tb_mul_share_arbiter;
   import mul_share_pkg::*;
   localparam int N = 3;
   localparam int W = 4;
   localparam int FC = 2 * W + 4;
   localparam int OW = 2 * W;
   typedef struct {int id; int o;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   mul_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
   mul_share_arbiter #(.N_REQ(N), .WIDTH(W), .FLUSH_CYC(FC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   exp_t exp_q[$];
   int acc_q[$];
   int grant_log[$];
   int checks = 0, failures = 0, mptr = 0, issues = 0, mg;
   bit prev_iv = 0, force2 = 0, slow = 0;
   exp_t e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: grant goes to the first valid requester at or after the pointer, product is a*b
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         mptr = 0;
         prev_iv = 0;
      end else begin
         if (bus.busy) chk("ready_while_busy", bus.req_ready, 0);
         if (!bus.busy && bus.req_valid != 0) chk("idle_grant", |bus.req_ready, 1);
         if (bus.req_ready != 0) begin
            mg = -1;
            for (int k = 0; k < N; k++)
               if (mg < 0 && bus.req_valid[(mptr + k) % N]) mg = (mptr + k) % N;
            chk("grant", bus.req_ready, (mg < 0) ? 0 : (1 << mg));
            chk("ready_vs_resp", bus.resp_valid, 0);
            if (mg >= 0) begin
               exp_q.push_back('{mg, int'(bus.req_a[mg*W +: W]) * int'(bus.req_b[mg*W +: W])});
               acc_q.push_back(mg);
               grant_log.push_back(mg);
            end
         end
         if (bus.mul_in_valid) begin
            chk("iv_pulse", prev_iv, 0);
            issues++;
            if (exp_q.size() > 0) chk("mul_ops", int'(bus.mul_a) * int'(bus.mul_b), exp_q[$].o);
`ifdef MUL_SHARE_ZERO_BYPASS_EN
            chk("bypass_nonzero", bus.mul_a != 0 && bus.mul_b != 0, 1);
`endif
         end
         prev_iv = bus.mul_in_valid;
         if (bus.resp_valid) chk("resp_after_done", bus.mul_out_valid, 0);
         if (bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) chk("resp_unexpected", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               chk("resp_id", bus.resp_id, e.id);
               chk("resp_o", bus.resp_o, e.o);
               mptr = (e.id + 1) % N;
            end
         end
      end
   end

   // External multiplier: no reset, variable latency, done held 1 or 2 cycles (garbage in cycle 2)
   initial begin
      logic [W-1:0] pa, pb;
      bit two;
      bus.mul_out_valid = 0;
      bus.mul_o = '0;
      forever begin
         @(negedge clk);
         if (bus.mul_in_valid) begin
            pa = bus.mul_a;
            pb = bus.mul_b;
            two = force2 || ($urandom_range(0, 1) == 1);
            repeat (slow ? W + 1 : $urandom_range(1, W + 1)) @(posedge clk);
            #1 bus.mul_o = OW'(pa) * OW'(pb);
            bus.mul_out_valid = 1;
            if (two) begin
               @(posedge clk);
               #1 bus.mul_o = ~bus.mul_o;
            end
            @(posedge clk);
            #1 bus.mul_out_valid = 0;
            bus.mul_o = OW'($urandom);
         end
      end
   end

   task automatic step();
      int g;
      @(posedge clk);
      #1;
      while (acc_q.size() > 0) begin
         g = acc_q.pop_front();
         bus.req_valid[g] = 1'b0;
      end
   endtask

   task automatic set_req(input int i, input int a, input int b);
      bus.req_valid[i] = 1'b1;
      bus.req_a[i*W +: W] = W'(a);
      bus.req_b[i*W +: W] = W'(b);
   endtask

   task automatic wait_until(input string name, input int sel, input int lim);
      logic s;
      s = 0;
      for (int t = 0; t < lim; t++) begin
         @(negedge clk);
         s = (sel == 0) ? bus.mul_in_valid : (sel == 1) ? bus.resp_valid : |bus.req_ready;
         if (s) break;
      end
      chk(name, s, 1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      bus.resp_ready = 1;
      while ((exp_q.size() != 0 || bus.req_valid != 0) && t < 300) begin
         step();
         t++;
      end
      chk("drain_done", t < 300, 1);
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      acc_q.delete();
      for (int c = 0; c < FC; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_resp_o", bus.resp_o, 0);
            chk("rst_resp_id", bus.resp_id, 0);
            chk("rst_mul_a", bus.mul_a, 0);
            chk("rst_mul_b", bus.mul_b, 0);
         end
         chk("flush_ready", bus.req_ready, 0);
         chk("flush_issue", bus.mul_in_valid, 0);
      end
      @(negedge clk);
      chk("flush_done_idle", bus.busy, 0);
   endtask

   initial begin
      int start;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.resp_ready = 1;
      do_reset();
      step();
      set_req(0, 3, 5);
      wait_until("t1_issue", 0, 20);
      chk("t1_mul_a", bus.mul_a, 3);
      chk("t1_mul_b", bus.mul_b, 5);
      wait_until("t1_resp", 1, 40);
      chk("t1_resp_o", bus.resp_o, 15);
      chk("t1_resp_id", bus.resp_id, 0);
      drain();
      grant_log.delete();
      start = mptr;
      for (int t = 0; t < 300 && grant_log.size() < 6; t++) begin
         step();
         for (int i = 0; i < N; i++)
            if (!bus.req_valid[i]) set_req(i, $urandom_range(1, 15), $urandom_range(1, 15));
      end
      bus.req_valid = '0;
      chk("t2_grants", grant_log.size(), 6);
      for (int k = 0; k < grant_log.size(); k++) chk("t2_order", grant_log[k], (start + k) % N);
      drain();
      step();
      bus.resp_ready = 0;
      set_req(1, 15, 15);
      wait_until("t3_resp", 1, 40);
      step();
      set_req(0, 2, 2);
      set_req(2, 3, 3);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t3_held", bus.resp_valid, 1);
         chk("t3_resp_o", bus.resp_o, 225);
         chk("t3_resp_id", bus.resp_id, 1);
         chk("t3_no_ready", bus.req_ready, 0);
      end
      drain();
      step();
      start = issues;
      set_req(2, 0, 9);
`ifdef MUL_SHARE_ZERO_BYPASS_EN
      wait_until("t4_accept", 2, 20);
      @(negedge clk);
      chk("t4_bypass_latency", bus.resp_valid, 1);
`else
      wait_until("t4_resp", 1, 40);
`endif
      chk("t4_resp_o", bus.resp_o, 0);
      drain();
`ifdef MUL_SHARE_ZERO_BYPASS_EN
      chk("t4_issues", issues - start, 0);
`else
      chk("t4_issues", issues - start, 1);
`endif
      slow = 1;
      step();
      set_req(1, 9, 9);
      wait_until("t5_issue", 0, 20);
      step();
      bus.req_valid = '0;
      set_req(0, 7, 6);
      do_reset();
      slow = 0;
      wait_until("t5_resp", 1, 40);
      chk("t5_resp_o", bus.resp_o, 42);
      chk("t5_resp_id", bus.resp_id, 0);
      drain();
      force2 = 1;
      step();
      set_req(2, 13, 11);
      wait_until("t6_resp", 1, 40);
      chk("t6_resp_o", bus.resp_o, 143);
      drain();
      force2 = 0;
      for (int t = 0; t < 400; t++) begin
         step();
         for (int i = 0; i < N; i++)
            if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
               set_req(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15),
                       ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15));
         bus.resp_ready = $urandom_range(0, 3) != 0;
      end
      bus.req_valid = '0;
      drain();
      chk("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end
endmodule
